// File: rtl/button_pulse_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM and optional
// hold-to-auto-repeat generator producing single-cycle press/release strobes.
// All outputs are registered; btn_in only ever reaches the FSM through the
// synchronizer.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_active
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    // Counters only ever reach PARAM-1, so $clog2(PARAM) bits are enough.
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [CNT_W-1:0] w_rep_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_rep_act;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_rep_act_nxt;
    logic             w_db_done;

    assign w_db_done = (r_db_cnt == DB_LAST);

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any disagreement during a debounce window aborts it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (r_s2) w_state_nxt = DB_PRESS;
            DB_PRESS:   if (!r_s2) w_state_nxt = IDLE;
                        else if (w_db_done) w_state_nxt = HELD;
            HELD:       if (!r_s2) w_state_nxt = DB_RELEASE;
            DB_RELEASE: if (r_s2) w_state_nxt = HELD;
                        else if (w_db_done) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Output and counter next values; counters stop at their terminal value
    // instead of wrapping, and a repeat is held off one cycle rather than
    // producing back-to-back press strobes.
    always_comb begin
        w_db_cnt_nxt   = r_db_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_rep_cnt_nxt  = r_rep_cnt;
        w_level_nxt    = r_level;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;
        w_rep_act_nxt  = r_rep_act;
        case (r_state)
            IDLE: begin
                w_db_cnt_nxt = '0;
            end
            DB_PRESS: begin
                if (r_s2) begin
                    if (w_db_done) begin
                        w_level_nxt    = 1'b1;
                        w_press_nxt    = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_rep_cnt_nxt  = '0;
                        w_rep_act_nxt  = 1'b0;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                    end
                end
            end
            HELD: begin
                if (!r_s2) begin
                    w_db_cnt_nxt = '0;
                end else if (REPEAT_EN) begin
                    if (!r_rep_act) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            if (!r_press) begin
                                w_press_nxt   = 1'b1;
                                w_rep_act_nxt = 1'b1;
                                w_rep_cnt_nxt = '0;
                            end
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + CNT_ONE;
                        end
                    end else begin
                        if (r_rep_cnt == REP_LAST) begin
                            if (!r_press) begin
                                w_press_nxt   = 1'b1;
                                w_rep_cnt_nxt = '0;
                            end
                        end else begin
                            w_rep_cnt_nxt = r_rep_cnt + CNT_ONE;
                        end
                    end
                end
            end
            DB_RELEASE: begin
                if (!r_s2) begin
                    if (w_db_done) begin
                        w_level_nxt   = 1'b0;
                        w_rep_act_nxt = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_rep_act  <= 1'b0;
        end else begin
            r_db_cnt   <= w_db_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_rep_act  <= w_rep_act_nxt;
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_active = r_rep_act;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner: one instance with auto-repeat
// (a) and one without (b) share the same button and reset stimulus.
module tb_button_pulse_conditioner;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 5;
    localparam int LAT = D + 3;   // drive at negedge N -> strobe visible at negedge N+D+3

    typedef struct {
        int cyc;
        bit p;
        bit r;
        bit l;
        bit ra;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic lvl_a, prs_a, rel_a, rep_a;
    logic lvl_b, prs_b, rel_b, rep_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q_a[$];
    ev_t  q_b[$];
    ev_t  e_a;
    ev_t  e_b;
    bit   prev_prs_a = 1'b0;
    bit   prev_prs_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(lvl_a), .press_pulse(prs_a),
        .release_pulse(rel_a), .repeat_active(rep_a)
    );

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(lvl_b), .press_pulse(prs_b),
        .release_pulse(rel_b), .repeat_active(rep_b)
    );

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %b, expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t e, input int c,
                          input bit p, input bit r, input bit l, input bit ra);
        checks++;
        if (e.cyc != c || e.p != p || e.r != r || e.l != l || e.ra != ra) begin
            errors++;
            $display("FAIL %s: got cyc=%0d press=%0b rel=%0b lvl=%0b rep=%0b, expected cyc=%0d press=%0b rel=%0b lvl=%0b rep=%0b",
                     nm, c, p, r, l, ra, e.cyc, e.p, e.r, e.l, e.ra);
        end
    endtask

    // Monitor for instance a: pops an expectation whenever a strobe appears.
    always @(negedge clk) begin
        if (prs_a || rel_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_a at cyc %0d: press=%0b rel=%0b, expected no strobe", cyc, prs_a, rel_a);
            end else begin
                e_a = q_a.pop_front();
                cmp_ev("event_a", e_a, cyc, prs_a, rel_a, lvl_a, rep_a);
            end
        end else if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
            e_a = q_a.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_a at cyc %0d: got no strobe, expected press=%0b rel=%0b", cyc, e_a.p, e_a.r);
        end
        chk("excl_a", {3'b000, prs_a & rel_a}, 4'b0000);
        chk("consec_a", {3'b000, prs_a & prev_prs_a}, 4'b0000);
        prev_prs_a = prs_a;
    end

    // Monitor for instance b (no auto-repeat).
    always @(negedge clk) begin
        if (prs_b || rel_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b at cyc %0d: press=%0b rel=%0b, expected no strobe", cyc, prs_b, rel_b);
            end else begin
                e_b = q_b.pop_front();
                cmp_ev("event_b", e_b, cyc, prs_b, rel_b, lvl_b, rep_b);
            end
        end else if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e_b = q_b.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_b at cyc %0d: got no strobe, expected press=%0b rel=%0b", cyc, e_b.p, e_b.r);
        end
        chk("excl_b", {3'b000, prs_b & rel_b}, 4'b0000);
        chk("consec_b", {3'b000, prs_b & prev_prs_b}, 4'b0000);
        chk("norep_b", {3'b000, rep_b}, 4'b0000);
        prev_prs_b = prs_b;
    end

    task automatic push_a(input int c, input bit p, input bit r, input bit l, input bit ra);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.l = l; e.ra = ra;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input bit p, input bit r, input bit l, input bit ra);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.l = l; e.ra = ra;
        q_b.push_back(e);
    endtask

    task automatic set_btn(input logic b, output int c);
        @(negedge clk);
        btn_in = b;
        c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_chk(input int n, input logic l);
        repeat (n) begin
            @(negedge clk);
            chk("level_a", {3'b000, lvl_a}, {3'b000, l});
            chk("level_b", {3'b000, lvl_b}, {3'b000, l});
        end
    endtask

    // Clean press held for 'hold' clocks, then a clean release.
    task automatic press_hold(input int hold);
        int c;
        int r;
        set_btn(1'b1, c);
        r = c + hold;
        push_a(c + LAT, 1, 0, 1, 0);
        push_b(c + LAT, 1, 0, 1, 0);
        // Auto-repeat strobes until the last HELD cycle before release is seen (r+2).
        for (int t = c + LAT + H; t <= r + 2; t += R) push_a(t, 1, 0, 1, 1);
        idle(hold - 1);
        set_btn(1'b0, c);
        push_a(c + LAT, 0, 1, 0, 0);
        push_b(c + LAT, 0, 1, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset  = 1'b0;
        btn_in = 1'b0;
        idle(3);
        chk("reset_a", {lvl_a, prs_a, rel_a, rep_a}, 4'b0000);
        chk("reset_b", {lvl_b, prs_b, rel_b, rep_b}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // Clean press, held 10 clocks, then release.
        press_hold(10);
        idle(12);

        // Bounce: 1,0,1,0 at 2-clock spacing, then stable 1.
        set_btn(1'b1, c); hold_chk(1, 1'b0);
        set_btn(1'b0, c); hold_chk(1, 1'b0);
        set_btn(1'b1, c); hold_chk(1, 1'b0);
        set_btn(1'b0, c); hold_chk(1, 1'b0);
        set_btn(1'b1, c);
        push_a(c + LAT, 1, 0, 1, 0);
        push_b(c + LAT, 1, 0, 1, 0);
        hold_chk(6, 1'b0);
        hold_chk(2, 1'b1);

        // Release glitch while HELD: 2 clocks low, then high again.
        set_btn(1'b0, c); hold_chk(1, 1'b1);
        set_btn(1'b1, c); hold_chk(8, 1'b1);
        set_btn(1'b0, c);
        push_a(c + LAT, 0, 1, 0, 0);
        push_b(c + LAT, 0, 1, 0, 0);
        idle(12);

        // Auto-repeat: held 60 clocks.
        press_hold(60);
        idle(12);

        // Long hold of 100 clocks; instance b must give exactly one press.
        press_hold(100);
        idle(12);

        // Asynchronous reset in the middle of HELD.
        set_btn(1'b1, c);
        push_a(c + LAT, 1, 0, 1, 0);
        push_b(c + LAT, 1, 0, 1, 0);
        idle(LAT);
        hold_chk(3, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_a", {lvl_a, prs_a, rel_a, rep_a}, 4'b0000);
        chk("async_rst_b", {lvl_b, prs_b, rel_b, rep_b}, 4'b0000);
        idle(3);
        chk("in_rst_a", {lvl_a, prs_a, rel_a, rep_a}, 4'b0000);
        chk("in_rst_b", {lvl_b, prs_b, rel_b, rep_b}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        c = cyc;
        push_a(c + LAT, 1, 0, 1, 0);
        push_b(c + LAT, 1, 0, 1, 0);
        hold_chk(LAT - 1, 1'b0);
        idle(3);
        set_btn(1'b0, c);
        push_a(c + LAT, 0, 1, 0, 0);
        push_b(c + LAT, 0, 1, 0, 0);
        idle(12);

        chk("drain_a", 4'(q_a.size()), 4'd0);
        chk("drain_b", 4'(q_b.size()), 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
